regfile_wb_arbiter: RTL

- Drives the single register-file write port: wr_en, wr_addr, wr_data, JumpAndLink and link_addr.
- Merges two result sources:
  - in-order pipeline writeback, which has priority;
  - a long-latency source (multiply/divide/load returns) through a valid/ready handshake, buffered in a small FIFO.
- Keeps a per-register pending scoreboard so decode can stall on registers whose long-latency result has not yet committed.

---
 rtl/regfile_wb_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//
// This block drives the single register-file write port. It merges two
// sources of results:
//   - in-order pipeline writeback, which always has priority;
//   - long-latency results (mul/div/load returns), which arrive through a
//     valid/ready handshake and are buffered in a DEPTH-entry FIFO.
// The FIFO drains only in cycles with no pipeline writeback.
//
// A 32-bit pending scoreboard marks registers whose long-latency result has
// not committed yet, so decode can stall on them. Bit 0 is always 0.
//
// Optional build macro:
//   WB_BYPASS_EN - if defined, a long-latency result that arrives while the
//                  FIFO is empty and no pipeline write is present goes
//                  straight to rf_* (1-cycle latency).
//
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   pipe_valid/_wr_addr/_wr_data/_jal/_link_addr
//                               pipeline writeback request
//   ll_issue_valid/_addr        marks a long-latency destination pending
//   ll_issue_conflict           the issued destination is already pending
//   ll_valid/_ready/_addr/_data long-latency result handshake
//   rf_wr_en/_wr_addr/_wr_data/_jal/_link_addr
//                               registered register-file write port
//   rd_addr0/1, rd_busy0/1      decode pending lookups
//   fifo_count                  long-latency FIFO occupancy
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_valid,
  input  logic [4:0]    pipe_wr_addr,
  input  logic [31:0]   pipe_wr_data,
  input  logic          pipe_jal,
  input  logic [31:0]   pipe_link_addr,
  input  logic          ll_issue_valid,
  input  logic [4:0]    ll_issue_addr,
  output logic          ll_issue_conflict,
  input  logic          ll_valid,
  output logic          ll_ready,
  input  logic [4:0]    ll_addr,
  input  logic [31:0]   ll_data,
  output logic          rf_wr_en,
  output logic [4:0]    rf_wr_addr,
  output logic [31:0]   rf_wr_data,
  output logic          rf_jal,
  output logic [31:0]   rf_link_addr,
  input  logic [4:0]    rd_addr0,
  input  logic [4:0]    rd_addr1,
  output logic          rd_busy0,
  output logic          rd_busy1,
  output logic [CW-1:0] fifo_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // FIFO storage; no reset needed since the pointers define validity
  logic [4:0]    addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [31:0]   pending;
  // The current rf_* write came from the long-latency path
  logic          from_ll;

  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          push;
  logic          bypass;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;

  logic          wr_en_next;
  logic [4:0]    wr_addr_next;
  logic [31:0]   wr_data_next;
  logic          jal_next;
  logic [31:0]   link_next;
  logic          from_ll_next;

  assign fifo_full  = (fifo_count == CW'(DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign head_addr  = addr_mem[rd_ptr];
  assign head_data  = data_mem[rd_ptr];

  // The FIFO drains only when the pipeline leaves the write port free
  assign pop = !pipe_valid && !fifo_empty;

`ifdef WB_BYPASS_EN
  assign bypass = !pipe_valid && fifo_empty && ll_valid;
`else
  assign bypass = 1'b0;
`endif

  // When full, a same-cycle pop frees the slot the push needs
  assign ll_ready = !fifo_full || (!pipe_valid && fifo_full);
  // A bypassed result is written directly and never enters the FIFO
  assign push     = ll_valid && ll_ready && !bypass;

  assign rd_busy0          = pending[rd_addr0];
  assign rd_busy1          = pending[rd_addr1];
  assign ll_issue_conflict = pending[ll_issue_addr];

  // Write-port selection: pipeline, then FIFO head, then bypass.
  // Fields that a cycle does not load keep their previous value.
  always_comb begin
    wr_en_next   = 1'b0;
    jal_next     = 1'b0;
    wr_addr_next = rf_wr_addr;
    wr_data_next = rf_wr_data;
    link_next    = rf_link_addr;
    from_ll_next = 1'b0;
    if (pipe_valid) begin
      if (pipe_jal) begin
        wr_en_next   = 1'b1;
        jal_next     = 1'b1;
        wr_addr_next = 5'd31;
        wr_data_next = 32'd0;
        link_next    = pipe_link_addr;
      end else if (pipe_wr_addr != 5'd0) begin
        wr_en_next   = 1'b1;
        wr_addr_next = pipe_wr_addr;
        wr_data_next = pipe_wr_data;
      end
    end else if (pop) begin
      // r0 entries are popped but produce no write
      wr_en_next   = (head_addr != 5'd0);
      wr_addr_next = head_addr;
      wr_data_next = head_data;
      from_ll_next = 1'b1;
    end else if (bypass) begin
      wr_en_next   = (ll_addr != 5'd0);
      wr_addr_next = ll_addr;
      wr_data_next = ll_data;
      from_ll_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wr_en     <= 1'b0;
      rf_wr_addr   <= 5'd0;
      rf_wr_data   <= 32'd0;
      rf_jal       <= 1'b0;
      rf_link_addr <= 32'd0;
      from_ll      <= 1'b0;
    end else begin
      rf_wr_en     <= wr_en_next;
      rf_wr_addr   <= wr_addr_next;
      rf_wr_data   <= wr_data_next;
      rf_jal       <= jal_next;
      rf_link_addr <= link_next;
      from_ll      <= from_ll_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= ll_addr;
      data_mem[wr_ptr] <= ll_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // Scoreboard. A bit clears on the edge where the register file commits
  // the long-latency write now on rf_*. A same-cycle issue to that register
  // wins over the clear.
  assign pending[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_pending
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pending[gi] <= 1'b0;
        end else if (ll_issue_valid && (ll_issue_addr == 5'(gi))) begin
          pending[gi] <= 1'b1;
        end else if (rf_wr_en && from_ll && (rf_wr_addr == 5'(gi))) begin
          pending[gi] <= 1'b0;
        end
      end
    end
  endgenerate

endmodule
